fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch stage of the core.
- Owns `current_pc` and issues single-outstanding requests to instruction memory.
- Delivers fetched instructions to decode over a valid/ready handshake, and applies branch/trap redirects.
- Raises `fetch_addr_misaligned` combinationally whenever `current_pc` is not word-aligned. The fetch-stage formal property depends on this: `current_pc % 4 != 0` implies `fetch_addr_misaligned`, checked on `clk` with `cpu_rstn` as the disable.

Parameters:
- XLEN, 32, address/PC width; matches the `XLEN` define.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  input  1  core clock
- cpu_rstn  input  1  reset; asynchronous, active-low
- redirect_valid  input  1  branch/jump/trap redirect strobe
- redirect_pc  input  XLEN  redirect target
- imem_req  output  1  fetch request
- imem_addr  output  XLEN  fetch address; always equals current_pc
- imem_gnt  input  1  request accepted
- imem_rvalid  input  1  response valid
- imem_rdata  input  32  response instruction
- instr_valid  output  1  instruction available to decode
- instr  output  32  instruction word
- instr_pc  output  XLEN  PC of instr
- id_ready  input  1  decode accepts instruction
- current_pc  output  XLEN  next PC to fetch
- fetch_addr_misaligned  output  1  equals |current_pc[1:0], combinational

Behaviour:
- Reset (cpu_rstn low, asynchronous):
  - current_pc=RESET_PC; state=BOOT.
  - instr_valid=0, instr=0, instr_pc=0, kill flag=0.
  - imem_req=0 throughout reset.
- States: BOOT, REQ, WAIT, FAULT.
- BOOT: imem_req=0; moves to REQ on the first clock edge after reset release.
- REQ:
  - imem_req=1 when all three hold: fetch_addr_misaligned=0, redirect_valid=0, and the output slot is free (instr_valid=0, or instr_valid&&id_ready this cycle). Otherwise imem_req=0.
  - On imem_req&&imem_gnt: current_pc+=4 (wraps modulo 2^XLEN); latch issued PC internally; go to WAIT.
  - If fetch_addr_misaligned=1: no request; go to FAULT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with kill=0: instr<=imem_rdata, instr_pc<=latched PC, instr_valid<=1; go to REQ.
  - On imem_rvalid with kill=1: discard the data, clear kill, go to REQ.
- FAULT: imem_req=0. Holds until redirect_valid, then current_pc<=redirect_pc and state goes to REQ.
- Output handshake:
  - instr, instr_pc and instr_valid stay stable while instr_valid&&!id_ready.
  - Transfer occurs when instr_valid&&id_ready; instr_valid clears the next cycle unless it is refilled that same edge.
- Redirect (any state, highest priority):
  - current_pc<=redirect_pc next cycle; instr_valid<=0.
  - In WAIT, or on a REQ cycle where gnt fires simultaneously: set kill; the outstanding response is dropped; state goes to WAIT, then REQ.
  - Redirect simultaneous with imem_rvalid in WAIT: the response is dropped, kill stays clear, state goes to REQ.
- Latency: the first request after rstn release is the 2nd rising edge; a grant-to-response delay of ≥1 cycle is tolerated with no upper bound.
- Misaligned redirect_pc: accepted into current_pc; the misalignment flag asserts in the same cycle; FAULT is then entered from REQ.
- Reset asserted mid-WAIT: the state machine returns to BOOT. A late imem_rvalid arriving in BOOT or REQ with no request outstanding is ignored.
- Exactly one outstanding request at any time; imem_addr is never presented while fetch_addr_misaligned=1.

Test Plan:
- Reset release, RESET_PC=0, gnt same cycle, rvalid one cycle later with rdata=0x00000013, id_ready=1 -> requests at 0x0, 0x4, 0x8; instr_valid pulses with instr_pc 0x0, 0x4.
- id_ready=0 held 5 cycles after the first instruction -> instr/instr_pc stable; imem_req=0 until id_ready rises, then a request at 0x4 in that cycle.
- redirect_valid with redirect_pc=0x100 while in WAIT for 0x8 -> response for 0x8 dropped (no instr_valid); next imem_addr=0x100; instr_pc=0x100 delivered.
- redirect_pc=0x102 -> fetch_addr_misaligned=1 the same cycle as current_pc=0x102; no imem_req; FAULT held; redirect to 0x200 resumes fetch at 0x200.
- current_pc=0xFFFF_FFFC granted -> current_pc wraps to 0x0; the next request is at 0x0.
- cpu_rstn asserted in WAIT, rvalid arrives during reset and on the first post-reset cycle -> both ignored; instr_valid=0; first request at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer with one request outstanding at a time.
// It owns current_pc, issues requests to instruction memory, hands the fetched
// words to decode over valid/ready, and applies branch/trap redirects.
//
// Ports:
//   clk, cpu_rstn                  core clock, asynchronous active-low reset
//   redirect_valid, redirect_pc    redirect strobe and target (highest priority)
//   imem_req, imem_addr            fetch request; the address is always current_pc
//   imem_gnt                       request accepted
//   imem_rvalid, imem_rdata        response strobe and instruction word
//   instr_valid, instr, instr_pc   instruction slot presented to decode
//   id_ready                       decode accepts the slot
//   current_pc                     next PC to fetch
//   fetch_addr_misaligned          |current_pc[1:0], combinational
module fetch_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            cpu_rstn,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            id_ready,
  output logic [XLEN-1:0] current_pc,
  output logic            fetch_addr_misaligned
);

  localparam int unsigned IW = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] pc_nx;
  logic [XLEN-1:0] issued_pc, issued_pc_nx;
  logic [XLEN-1:0] instr_pc_nx;
  logic [IW-1:0]   instr_nx;
  logic            instr_valid_nx;
  logic            kill, kill_nx;
  logic            slot_free;

  assign fetch_addr_misaligned = |current_pc[1:0];
  assign imem_addr             = current_pc;
  // The slot can take a new word if it is empty or is being drained this cycle.
  assign slot_free             = !instr_valid || id_ready;

  // Next-state and output logic.
  always_comb begin
    state_nx       = state;
    pc_nx          = current_pc;
    issued_pc_nx   = issued_pc;
    instr_nx       = instr;
    instr_pc_nx    = instr_pc;
    kill_nx        = kill;
    instr_valid_nx = instr_valid && !id_ready;
    imem_req       = 1'b0;

    case (state)
      BOOT: state_nx = REQ;
      REQ: begin
        imem_req = !fetch_addr_misaligned && !redirect_valid && slot_free;
        if (imem_req && imem_gnt) begin
          pc_nx        = current_pc + XLEN'(4);
          issued_pc_nx = current_pc;
          state_nx     = WAIT;
        end else if (fetch_addr_misaligned) begin
          state_nx = FAULT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (!kill) begin
            instr_nx       = imem_rdata;
            instr_pc_nx    = issued_pc;
            instr_valid_nx = 1'b1;
          end
          kill_nx  = 1'b0;
          state_nx = REQ;
        end
      end
      FAULT: state_nx = FAULT;
      default: state_nx = BOOT;
    endcase

    // Redirect overrides everything above; an in-flight response becomes stale.
    if (redirect_valid) begin
      pc_nx          = redirect_pc;
      instr_valid_nx = 1'b0;
      instr_nx       = instr;
      instr_pc_nx    = instr_pc;
      case (state)
        WAIT: begin
          if (imem_rvalid) begin
            kill_nx  = 1'b0;
            state_nx = REQ;
          end else begin
            kill_nx  = 1'b1;
            state_nx = WAIT;
          end
        end
        REQ: begin
          if (imem_gnt) begin
            kill_nx  = 1'b1;
            state_nx = WAIT;
          end else begin
            state_nx = REQ;
          end
        end
        default: state_nx = REQ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge cpu_rstn) begin
    if (!cpu_rstn) state <= BOOT;
    else           state <= state_nx;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      current_pc  <= RESET_PC;
      issued_pc   <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      kill        <= 1'b0;
    end else begin
      current_pc  <= pc_nx;
      issued_pc   <= issued_pc_nx;
      instr       <= instr_nx;
      instr_pc    <= instr_pc_nx;
      instr_valid <= instr_valid_nx;
      kill        <= kill_nx;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized bench for fetch_ctrl against a transaction-level
// model of the fetch rules, with a responsive instruction-memory model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        cpu_rstn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        id_ready;
  logic [31:0] current_pc;
  logic        fetch_addr_misaligned;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  fetch_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .cpu_rstn(cpu_rstn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .id_ready(id_ready), .current_pc(current_pc),
    .fetch_addr_misaligned(fetch_addr_misaligned)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pc, one outstanding fetch (possibly stale), decode slot.
  logic [31:0] m_pc, m_issued, m_instr, m_ipc;
  logic        m_boot, m_wait, m_stale, m_valid;

  // Memory model.
  logic        mem_busy;
  int          mem_cnt;
  int          dmin, dmax;

  // Stimulus knobs and one-shot overrides.
  int          p_gnt, p_rdy, p_redir, p_mis, p_spur;
  logic        fixed_data;
  logic        frc_rv, frc_rvalid, rel;
  logic [31:0] frc_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_issued = '0; m_instr = '0; m_ipc = '0;
    m_boot = 1'b1; m_wait = 1'b0; m_stale = 1'b0; m_valid = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check request, advance model.
  task automatic step();
    logic        rv, rdy, rvl, gnt, exp_req;
    logic [31:0] rpc, rdat, r;
    @(negedge clk);
    check("current_pc", current_pc, m_pc);
    check("misaligned", 32'(fetch_addr_misaligned), 32'(m_pc[1:0] != 2'b00));
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("instr", instr, m_instr);
    check("instr_pc", instr_pc, m_ipc);
    if (rel) begin
      cpu_rstn = 1'b1;
      rel = 1'b0;
    end

    rv = 1'b0;
    rpc = $urandom;
    if (frc_rv) begin
      rv = 1'b1; rpc = frc_pc; frc_rv = 1'b0;
    end else if ($urandom_range(99) < p_redir) begin
      r = $urandom;
      rv = 1'b1;
      rpc = ($urandom_range(99) < p_mis) ? r : {r[31:2], 2'b00};
    end
    rdy  = ($urandom_range(99) < p_rdy);
    rvl  = mem_busy && (mem_cnt == 0);
    rdat = fixed_data ? 32'h0000_0013 : $urandom;
    if (frc_rvalid || (!m_wait && ($urandom_range(99) < p_spur))) rvl = 1'b1;
    frc_rvalid = 1'b0;

    redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
    imem_rvalid = rvl; imem_rdata = rdat; imem_gnt = 1'b0;
    #1;
    exp_req = !m_boot && !m_wait && (m_pc[1:0] == 2'b00) && !rv && (!m_valid || rdy);
    check("imem_req", 32'(imem_req), 32'(exp_req));
    check("imem_addr", imem_addr, m_pc);
    gnt = exp_req && ($urandom_range(99) < p_gnt);
    imem_gnt = gnt;

    // Memory: retire the response, count down, or accept a new request.
    if (mem_busy && mem_cnt == 0) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (exp_req && gnt) begin
      mem_busy = 1'b1;
      mem_cnt = $urandom_range(dmax, dmin);
    end

    // Model update.
    if (m_valid && rdy) m_valid = 1'b0;
    if (rv) begin
      m_pc = rpc; m_valid = 1'b0; m_boot = 1'b0;
      if (m_wait) begin
        if (rvl) begin m_wait = 1'b0; m_stale = 1'b0; end
        else m_stale = 1'b1;
      end
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_wait) begin
      if (rvl) begin
        if (!m_stale) begin
          m_valid = 1'b1; m_instr = rdat; m_ipc = m_issued;
        end
        m_stale = 1'b0; m_wait = 1'b0;
      end
    end else if (exp_req && gnt) begin
      m_issued = m_pc;
      m_pc = m_pc + 32'd4;
      m_wait = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until a fetch is outstanding (optionally with response still pending).
  task automatic run_to_wait(input logic need_delay);
    logic found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_wait && (!need_delay || (mem_busy && mem_cnt > 0))) found = 1'b1;
      else step();
    end
    check("wait_bound", 32'(found), 32'd1);
  endtask

  task automatic set_knobs(input int g, input int rd, input int re, input int mi, input int lo, input int hi);
    p_gnt = g; p_rdy = rd; p_redir = re; p_mis = mi; dmin = lo; dmax = hi;
  endtask

  initial begin
    cpu_rstn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    frc_rv = 1'b0; frc_pc = '0; frc_rvalid = 1'b0; rel = 1'b0; p_spur = 0;
    fixed_data = 1'b1;
    set_knobs(100, 100, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", current_pc, RST_PC);

    // Back-to-back fetch, immediate grant and response.
    rel = 1'b1;
    run(8);
    fixed_data = 1'b0;

    // Decode stalls with a word held in the slot.
    set_knobs(100, 0, 0, 0, 0, 0);
    run(5);
    set_knobs(100, 100, 0, 0, 0, 0);
    run(4);

    // Redirect while the response is still pending: response is dropped.
    set_knobs(100, 100, 0, 0, 2, 2);
    run_to_wait(1'b1);
    frc_rv = 1'b1; frc_pc = 32'h0000_0100;
    run(10);

    // Redirect coinciding with the response.
    set_knobs(100, 100, 0, 0, 0, 0);
    run_to_wait(1'b0);
    frc_rv = 1'b1; frc_pc = 32'h0000_0040;
    run(6);

    // Misaligned redirect parks fetch until an aligned redirect.
    frc_rv = 1'b1; frc_pc = 32'h0000_0102;
    run(5);
    frc_rv = 1'b1; frc_pc = 32'h0000_0200;
    run(6);

    // PC wrap at the top of the address space.
    frc_rv = 1'b1; frc_pc = 32'hFFFF_FFFC;
    run(6);

    // Reset asserted mid-fetch, with stray responses during and just after reset.
    set_knobs(100, 100, 0, 0, 3, 3);
    run_to_wait(1'b1);
    @(negedge clk);
    cpu_rstn = 1'b0; imem_rvalid = 1'b1; imem_gnt = 1'b0; redirect_valid = 1'b0;
    model_reset();
    #1;
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_pc", current_pc, RST_PC);
    @(negedge clk);
    #1;
    check("midrst_req2", 32'(imem_req), 32'd0);
    rel = 1'b1; frc_rvalid = 1'b1;
    set_knobs(100, 100, 0, 0, 0, 2);
    run(8);

    // Random traffic.
    p_spur = 5;
    set_knobs(60, 70, 4, 20, 0, 4);
    run(3000);
    set_knobs(90, 95, 1, 10, 0, 1);
    run(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
